// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: FSM state codes, Q14 twiddle constants and LUT,
// and the 16-QAM Gray level codes used by both modulator and demodulator.
package ofdm_pkg;

    localparam int N_SC = 8;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    localparam logic signed [15:0] Q14_ONE = 16'sd16384;
    localparam logic signed [15:0] Q14_R2  = 16'sd11585;
    localparam logic signed [15:0] Q14_Z   = 16'sd0;

    localparam logic [1:0] QAM_LVL_M3 = 2'b00;
    localparam logic [1:0] QAM_LVL_M1 = 2'b01;
    localparam logic [1:0] QAM_LVL_P1 = 2'b11;
    localparam logic [1:0] QAM_LVL_P3 = 2'b10;

    typedef struct packed {
        logic signed [15:0] c;
        logic signed [15:0] s;
    } twiddle_t;

    // cos/sin of 2*pi*m/8 in Q14
    function automatic twiddle_t twiddle(input logic [2:0] m);
        twiddle_t t;
        case (m)
            3'd0:    begin t.c = Q14_ONE;  t.s = Q14_Z;    end
            3'd1:    begin t.c = Q14_R2;   t.s = Q14_R2;   end
            3'd2:    begin t.c = Q14_Z;    t.s = Q14_ONE;  end
            3'd3:    begin t.c = -Q14_R2;  t.s = Q14_R2;   end
            3'd4:    begin t.c = -Q14_ONE; t.s = Q14_Z;    end
            3'd5:    begin t.c = -Q14_R2;  t.s = -Q14_R2;  end
            3'd6:    begin t.c = Q14_Z;    t.s = -Q14_ONE; end
            3'd7:    begin t.c = Q14_R2;   t.s = -Q14_R2;  end
            default: begin t.c = Q14_ONE;  t.s = Q14_Z;    end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/qam16_slicer.sv
// Per-axis 16-QAM decision: maps a full-precision DFT bin value to a Gray
// level code; exact boundaries resolve toward the larger level.
module qam16_slicer
    import ofdm_pkg::*;
#(
    parameter int ACC_W = 36
) (
    input  logic [ACC_W-1:0] value,
    input  logic [ACC_W-1:0] thr,
    output logic [1:0]       code
);

    localparam logic signed [ACC_W-1:0] ZERO = '0;

    logic signed [ACC_W-1:0] v_s;
    logic signed [ACC_W-1:0] t_s;

    // Four-region threshold compare
    always_comb begin
        v_s  = $signed(value);
        t_s  = $signed(thr);
        code = QAM_LVL_M3;
        if (v_s < -t_s) begin
            code = QAM_LVL_M3;
        end else if (v_s < ZERO) begin
            code = QAM_LVL_M1;
        end else if (v_s < t_s) begin
            code = QAM_LVL_P1;
        end else begin
            code = QAM_LVL_P3;
        end
    end

endmodule

// File: rtl/ofdm_demodulator.sv
// 8-point OFDM receiver: buffers a frame of samples, runs a sequential
// single-MAC forward DFT, slices every bin to a 16-QAM nibble.
module ofdm_demodulator
    import ofdm_pkg::*;
#(
    parameter int INPUT_WIDTH  = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int AMP          = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SAMPLE_WIDTH-1:0]    in_re,
    input  logic [SAMPLE_WIDTH-1:0]    in_im,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [8*INPUT_WIDTH-1:0]   data_out
);

    localparam int ACC_W = SAMPLE_WIDTH + 20;
    localparam logic signed [ACC_W-1:0] THR = ACC_W'(16 * AMP * 16384);

    logic [1:0]              state_r;
    logic [2:0]              n_r;
    logic [2:0]              k_r;
    logic [SAMPLE_WIDTH-1:0] smp_re_r [N_SC];
    logic [SAMPLE_WIDTH-1:0] smp_im_r [N_SC];
    logic signed [ACC_W-1:0] acc_re_r;
    logic signed [ACC_W-1:0] acc_im_r;
    logic [8*INPUT_WIDTH-1:0] data_r;
    logic                    in_ready_r;
    logic                    out_valid_r;

    logic [2:0]              m_s;
    twiddle_t                tw_s;
    logic signed [ACC_W-1:0] xr_s, xi_s, c_s, s_s;
    logic signed [ACC_W-1:0] sum_re_s, sum_im_s;
    logic [1:0]              code_re_s, code_im_s;

    // Complex MAC: operands sign-extended to accumulator width, so no precision loss
    always_comb begin
        m_s  = n_r * k_r;
        tw_s = twiddle(m_s);
        xr_s = ACC_W'($signed(smp_re_r[n_r]));
        xi_s = ACC_W'($signed(smp_im_r[n_r]));
        c_s  = ACC_W'($signed(tw_s.c));
        s_s  = ACC_W'($signed(tw_s.s));
        if (n_r == 3'd0) begin
            sum_re_s = xr_s * c_s + xi_s * s_s;
            sum_im_s = xi_s * c_s - xr_s * s_s;
        end else begin
            sum_re_s = acc_re_r + xr_s * c_s + xi_s * s_s;
            sum_im_s = acc_im_r + xi_s * c_s - xr_s * s_s;
        end
    end

    qam16_slicer #(.ACC_W(ACC_W)) u_slice_re (
        .value (sum_re_s),
        .thr   (THR),
        .code  (code_re_s)
    );

    qam16_slicer #(.ACC_W(ACC_W)) u_slice_im (
        .value (sum_im_s),
        .thr   (THR),
        .code  (code_im_s)
    );

    // Frame FSM: load samples, walk k/n through the DFT, hold result until taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_LOAD;
            n_r         <= 3'd0;
            k_r         <= 3'd0;
            acc_re_r    <= '0;
            acc_im_r    <= '0;
            data_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < N_SC; i++) begin
                smp_re_r[i] <= '0;
                smp_im_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (in_valid) begin
                        smp_re_r[n_r] <= in_re;
                        smp_im_r[n_r] <= in_im;
                        n_r           <= n_r + 3'd1;
                        if (n_r == 3'd7) begin
                            state_r    <= ST_COMPUTE;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    acc_re_r <= sum_re_s;
                    acc_im_r <= sum_im_s;
                    n_r      <= n_r + 3'd1;
                    if (n_r == 3'd7) begin
                        data_r[INPUT_WIDTH*k_r +: INPUT_WIDTH] <= {code_re_s, code_im_s};
                        k_r <= k_r + 3'd1;
                        if (k_r == 3'd7) begin
                            state_r     <= ST_OUTPUT;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        state_r     <= ST_LOAD;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_LOAD;
                    n_r         <= 3'd0;
                    k_r         <= 3'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign data_out  = data_r;

endmodule

// File: tb/tb_ofdm_demodulator.sv
// Directed bench for ofdm_demodulator: impulse frames with hand-derived
// nibbles, latency, backpressure, input gaps and mid-frame resets.
module tb_ofdm_demodulator;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        data_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [15:0] fr_re [8];
    logic signed [15:0] fr_im [8];

    always #5 clk = ~clk;

    ofdm_demodulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_impulse(input int idx, input logic signed [15:0] re, input logic signed [15:0] im);
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = 16'sd0;
            fr_im[i] = 16'sd0;
        end
        fr_re[idx] = re;
        fr_im[idx] = im;
    endtask

    // Entered and left at 1 ns after a rising edge
    task automatic send_sample(input logic signed [15:0] re, input logic signed [15:0] im, input int max_gap);
        int  gap;
        int  cnt;
        logic rdy;
        logic done;
        gap  = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 200) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            done = rdy;
            cnt++;
        end
        in_valid = 1'b0;
        if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_frame(input int max_gap);
        for (int i = 0; i < 8; i++) send_sample(fr_re[i], fr_im[i], max_gap);
    endtask

    task automatic wait_frame(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_frame(input string tag, input logic [31:0] exp, input int max_gap);
        int lat;
        load_frame(max_gap);
        wait_frame(lat);
        check_eq({tag, "_latency"}, 32'(lat), 32'd64);
        check_eq({tag, "_data"}, data_out, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
        check_eq({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_data_out", data_out, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int lat;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_re     = 16'sd0;
        in_im     = 16'sd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset_data_out", data_out, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        set_impulse(0, 16'sd8, 16'sd8);
        run_frame("y0_p8p8", 32'hFFFF_FFFF, 0);
        set_impulse(0, -16'sd24, -16'sd24);
        run_frame("y0_m24m24", 32'h0000_0000, 0);
        set_impulse(1, 16'sd8, 16'sd0);
        run_frame("y1_p8", 32'hFF77_5DDF, 0);
        set_impulse(0, 16'sd16, -16'sd16);
        run_frame("y0_thresh", 32'h9999_9999, 0);

        // Backpressure with a garbage sample offered the whole time
        set_impulse(0, 16'sd16, -16'sd16);
        load_frame(0);
        wait_frame(lat);
        check_eq("bp_latency", 32'(lat), 32'd64);
        in_valid = 1'b1;
        in_re    = 16'sd100;
        in_im    = -16'sd100;
        repeat (10) begin
            @(posedge clk);
            #1;
            check_eq("bp_data_stable", data_out, 32'h9999_9999);
            check_eq("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check_eq("bp_out_valid_high", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        set_impulse(0, 16'sd8, 16'sd8);
        run_frame("post_bp", 32'hFFFF_FFFF, 0);

        // Back-to-back frames with random input gaps
        set_impulse(1, 16'sd8, 16'sd0);
        run_frame("gap_a", 32'hFF77_5DDF, 3);
        set_impulse(0, -16'sd24, -16'sd24);
        run_frame("gap_b", 32'h0000_0000, 3);

        // Reset during COMPUTE
        set_impulse(0, 16'sd16, -16'sd16);
        load_frame(2);
        repeat (20) @(posedge clk);
        #1;
        check_eq("mid_compute_out_valid", {31'd0, out_valid}, 32'd0);
        pulse_reset();
        set_impulse(0, 16'sd8, 16'sd8);
        run_frame("after_rst_compute", 32'hFFFF_FFFF, 3);

        // Reset after 5 loaded samples
        for (int i = 0; i < 5; i++) send_sample(16'sd100, 16'sd100, 2);
        pulse_reset();
        set_impulse(1, 16'sd8, 16'sd0);
        run_frame("after_rst_load", 32'hFF77_5DDF, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_demodulator.md
# ofdm_demodulator

Receive-side counterpart of the 8-subcarrier OFDM `modulator`. It accepts one complex time-domain sample per handshake and buffers a frame of 8 samples. It then computes an 8-point forward DFT with a single sequential complex MAC, slices each bin to a 16-QAM symbol, and presents the 8 recovered nibbles packed exactly as `modulator` expects its `data_in`. It sits after the channel/sample source and returns the payload to the packet layer.

## Interface
- `INPUT_WIDTH`, 4: bits per recovered symbol (16-QAM nibble).
- `SAMPLE_WIDTH`, 16: signed width of incoming re/im samples; matches modulator `OUTPUT_WIDTH`.
- `AMP`, 1: unit constellation amplitude used by the modulator (levels ±1·AMP, ±3·AMP).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  block can accept a sample.
- `in_re`, `in_im`  in  SAMPLE_WIDTH each  signed sample y_n.
- `out_valid`  out  1  recovered frame valid.
- `out_ready`  in  1  consumer accepts frame.
- `data_out`  out  8*INPUT_WIDTH  bin k nibble at bits [4k+3:4k].

## Operation
- States:
  - LOAD: `in_ready`=1. Each edge with `in_valid` stores the sample at index n and increments n. When n=7 is accepted, go to COMPUTE.
  - COMPUTE: `in_ready`=0. Runs 64 MAC cycles, k outer (0..7) and n inner (0..7).
  - OUTPUT: `out_valid`=1 and `data_out` held stable until `out_valid&out_ready`, then go to LOAD.
- MAC:
  - Twiddle index m=(n·k) mod 8.
  - c=cos(2πm/8), s=sin(2πm/8) in Q14, values from {0, ±16384, ±11585}.
  - re += xr·c + xi·s; im += xi·c − xr·s.
  - Products and accumulation are full precision, with no rounding or truncation. Accumulator width is SAMPLE_WIDTH+20 (36 by default).
  - The accumulator clears at the start of each bin.
- Slicer, applied to each axis at the edge that completes bin k (acc + final product):
  - T = 16·AMP·16384.
  - v < −T → 00 (−3).
  - −T ≤ v < 0 → 01 (−1).
  - 0 ≤ v < T → 11 (+1).
  - v ≥ T → 10 (+3).
  - The real axis gives nibble bits [3:2] and the imaginary axis gives bits [1:0].
  - Exact boundaries round upward, so 0 → +1 and T → +3.
- The completed nibble is written into the `data_out` register at slot k.

## Timing
- Reset values: `in_ready`=1 (state LOAD), `out_valid`=0, `data_out`=0, n=k=0, accumulators 0.
- Reset asserted mid-frame discards the partial frame and all buffered samples.
- LOAD:
  - Accepts at most one sample per edge.
  - Gaps in `in_valid` stall n with no timeout.
- Latency:
  - Last sample accepted at edge E0; COMPUTE occupies edges E1..E64.
  - `out_valid` rises after E64.
  - With `out_ready` high, the frame transfers at E65 and `in_ready` is high after E65.
- Minimum frame period is 73 cycles.
- While `out_valid`=1 and `out_ready`=0, `data_out` and `out_valid` are stable and `in_ready` stays 0.
- No input is accepted in the cycle of an output handshake.
- During COMPUTE, `data_out` holds the previous frame's bins for slots not yet overwritten, but `out_valid` is 0.

## Structure
- Shared `ofdm_pkg` holds:
  - state enum (LOAD/COMPUTE/OUTPUT);
  - Q14 constants (16384, 11585);
  - 8-entry cos/sin twiddle LUT;
  - 16-QAM Gray level codes (00,01,11,10).
  - The modulator imports the same level codes.
- One natural sub-module, `qam16_slicer`, is combinational: accumulator value and T in, 2-bit code out, instantiated once per axis.

## Test plan
- y0=(8,8), y1..y7=0 → `data_out`=32'hFFFF_FFFF, `out_valid` after exactly 64 cycles following the last accept.
- y0=(−24,−24), others 0 → 32'h0000_0000.
- y1=(8,0), others 0 → 32'hFF77_5DDF; covers the 45° twiddles and zero-boundary rounding.
- y0=(16,−16), others 0 → 32'h9999_9999; covers the exact-threshold boundary.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `data_out` stable and `in_ready`=0 throughout. Release → one transfer, then `in_ready`=1 on the next cycle.
- Two cases with random `in_valid` gaps, back-to-back frames:
  - Reset pulse during COMPUTE → `out_valid`=0 and `in_ready`=1 immediately. The next full frame y0=(8,8) decodes to 32'hFFFF_FFFF.
  - Reset after 5 loaded samples → those 5 samples are not used.
